axi_sram_slave: RTL

- AXI3 responder modelling main memory on the far side of the CPU's SRAM-to-AXI bridge.
- Accepts read bursts (INCR, used by icache line refills) and single-beat writes, and serves them from an internal word-addressed memory array.
- Has a programmable read latency so benches can exercise bridge stall paths.
- Independent read and write engines; each has one outstanding transaction.

---
 rtl/axi_sram_slave.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 memory responder: INCR read bursts with programmable first-beat latency and
// single-beat byte-masked writes, served from a word-addressed internal array.
module axi_sram_slave #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RD_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  // R_WAIT always lasts at least one cycle, even with RD_DELAY of 0.
  localparam int unsigned WaitLast = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;
  localparam int unsigned CntW     = (WaitLast > 0) ? $clog2(WaitLast + 1) : 1;

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WCommit, WResp} w_state_e;

  logic [31:0] mem [Depth];

  r_state_e            r_state_q, r_state_d;
  logic [31:0]         r_addr_q;
  logic [7:0]          r_len_q, r_beat_q;
  logic                r_burst_err_q;
  logic [CntW-1:0]     wait_cnt_q;
  logic [3:0]          rid_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                wait_done;

  w_state_e            w_state_q, w_state_d;
  logic                aw_held_q, w_held_q;
  logic [ADDR_W-1:0]   aw_idx_q;
  logic                aw_err_q;
  logic [31:0]         w_data_q;
  logic [3:0]          w_strb_q;
  logic                w_last_q;
  logic [3:0]          bid_q;
  logic [1:0]          bresp_q;
  logic                wr_en;
  logic [31:0]         wr_word;

  logic [31:0]         ld_addr, ld_word, ld_data;
  logic [ADDR_W-1:0]   ld_idx;
  logic                ld_err;
  logic [1:0]          ld_resp;
  logic                unused_bits;

  assign unused_bits = ^{wid, awaddr[1:0], ld_addr[1:0]};

  // ---------------- write engine ----------------
  assign wr_en = (w_state_q == WCommit) && !aw_err_q && w_last_q && !reset;

  always_comb begin
    wr_word = mem[aw_idx_q];
    for (int b = 0; b < 4; b++) begin
      if (w_strb_q[b]) wr_word[8*b +: 8] = w_data_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[aw_idx_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) w_state_q <= WIdle;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      WIdle:   if (aw_held_q && w_held_q) w_state_d = WCommit;
      WCommit: w_state_d = WResp;
      WResp:   if (bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    awready = (w_state_q == WIdle) && !aw_held_q;
    wready  = (w_state_q == WIdle) && !w_held_q;
    bvalid  = (w_state_q == WResp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (awvalid && !aw_held_q) begin
            aw_held_q <= 1'b1;
            bid_q     <= awid;
            aw_idx_q  <= awaddr[ADDR_W+1:2];
            aw_err_q  <= (awaddr[31:ADDR_W+2] != '0) || (awlen != 8'd0) ||
                         (awburst != 2'b01) || (awsize > 3'd2);
          end
          if (wvalid && !w_held_q) begin
            w_held_q <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            w_last_q <= wlast;
          end
        end
        WCommit: bresp_q <= (aw_err_q || !w_last_q) ? 2'b10 : 2'b00;
        WResp: begin
          if (bready) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bid   = bid_q;
  assign bresp = bresp_q;

  // ---------------- read engine ----------------
  assign wait_done = (wait_cnt_q == CntW'(WaitLast));
  assign ld_addr   = (r_state_q == RData) ? r_addr_q + 32'd4 : r_addr_q;
  assign ld_idx    = ld_addr[ADDR_W+1:2];
  assign ld_err    = r_burst_err_q || (ld_addr[31:ADDR_W+2] != '0);
  // Forward a write committing on the same edge so the loaded beat sees it.
  assign ld_word   = (wr_en && (aw_idx_q == ld_idx)) ? wr_word : mem[ld_idx];
  assign ld_data   = ld_err ? 32'd0 : ld_word;
  assign ld_resp   = ld_err ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) r_state_q <= RIdle;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      RIdle:   if (arvalid) r_state_d = RWait;
      RWait:   if (wait_done) r_state_d = RData;
      RData:   if (rready && rlast) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (r_state_q)
      RIdle: arready = 1'b1;
      RData: begin
        rvalid = 1'b1;
        rlast  = (r_beat_q == r_len_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_q      <= '0;
      r_len_q       <= '0;
      r_beat_q      <= '0;
      r_burst_err_q <= 1'b0;
      wait_cnt_q    <= '0;
      rid_q         <= '0;
      rdata_q       <= '0;
      rresp_q       <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (arvalid) begin
            rid_q         <= arid;
            r_addr_q      <= araddr;
            r_len_q       <= arlen;
            r_beat_q      <= '0;
            wait_cnt_q    <= '0;
            r_burst_err_q <= (arburst != 2'b01) || (arsize > 3'd2);
          end
        end
        RWait: begin
          if (wait_done) begin
            rdata_q <= ld_data;
            rresp_q <= ld_resp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        RData: begin
          if (rready && !rlast) begin
            r_addr_q <= ld_addr;
            r_beat_q <= r_beat_q + 8'd1;
            rdata_q  <= ld_data;
            rresp_q  <= ld_resp;
          end
        end
        default: ;
      endcase
    end
  end

  assign rid   = rid_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;

endmodule
